// File: rtl/hex_scan_display_pkg.sv
// ============================================================================
// Module      : hex_scan_display_pkg
// Description : Shared segment encodings for the hex scan display driver.
//               Segment bit order: bit0=a, bit1=b, ... bit6=g; 1 = lit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_scan_display_pkg;

    localparam int SEG_W = 7;

    // Bit positions of the individual segments inside a segment code
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F_BIT = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b1111100; // lower-case b
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b0111001;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b1011110; // lower-case d
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b1110001;

endpackage

`default_nettype wire

// File: rtl/hex_scan_display_seg_decode.sv
// ============================================================================
// Module      : hex_seg_decode
// Description : Combinational 4-bit nibble to 7-segment code decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_seg_decode
    import hex_scan_display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    // Table lookup of the hex glyph for one nibble
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hex_scan_display.sv
// ============================================================================
// Module      : hex_scan_display
// Description : Time-multiplexed, double-buffered 7-segment hex display
//               driver. One digit enabled at a time for SCAN_DIV cycles.
//               Optional leading-zero blanking with HEX_SCAN_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_scan_display
    import hex_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
`ifdef HEX_SCAN_LZB_EN
    input  logic                    blank_lz,
`endif
    output logic [SEG_W-1:0]        d7seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]      cnt_q,          cnt_d;
    logic [IDX_W-1:0]      idx_q,          idx_d;
    logic [VAL_W-1:0]      pend_val_q,     pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q,      pend_dp_d;
    logic                  pend_valid_q,   pend_valid_d;
    logic [VAL_W-1:0]      disp_val_q,     disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q,      disp_dp_d;
    logic [SEG_W-1:0]      d7seg_q,        d7seg_d;
    logic                  dp_q,           dp_d;
    logic [NUM_DIGITS-1:0] digit_sel_q,    digit_sel_d;
    logic                  frame_done_q,   frame_done_d;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [3:0]            w_cur_nibble;
    logic [SEG_W-1:0]      w_cur_seg;
    logic                  w_blank;

    assign w_cur_nibble = disp_val_q[{idx_q, 2'b00} +: 4];

    hex_seg_decode u_seg_decode (
        .nibble (w_cur_nibble),
        .seg    (w_cur_seg)
    );

`ifdef HEX_SCAN_LZB_EN
    // w_zero_from[i]: digit i and every higher digit hold zero
    logic [NUM_DIGITS-1:0] w_zero_from;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero_from
        assign w_zero_from[gi] = ~|disp_val_q[VAL_W-1:4*gi];
    end

    // Digit 0 is never blanked so a zero value still shows "0"
    assign w_blank = blank_lz && (idx_q != '0) && w_zero_from[idx_q];
`else
    assign w_blank = 1'b0;
`endif

    // Next-state: prescaler, digit index, pending/display buffers, outputs
    always_comb begin
        w_slot_end  = (cnt_q == LAST_CNT);
        w_frame_end = w_slot_end && (idx_q == LAST_IDX);

        cnt_d = w_slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (w_slot_end) begin
            idx_d = w_frame_end ? '0 : idx_q + 1'b1;
        end

        // Last load wins; a load on the boundary edge stays pending
        pend_val_d   = load ? value : pend_val_q;
        pend_dp_d    = load ? dp_in : pend_dp_q;
        pend_valid_d = load ? 1'b1 : (w_frame_end ? 1'b0 : pend_valid_q);

        // Commit only at the frame boundary so a frame never tears
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (w_frame_end && pend_valid_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
        end

        digit_sel_d  = NUM_DIGITS'(1) << idx_q;
        d7seg_d      = w_blank ? SEG_BLANK : w_cur_seg;
        dp_d         = disp_dp_q[idx_q];
        frame_done_d = w_frame_end;
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            d7seg_q      <= SEG_BLANK;
            dp_q         <= 1'b0;
            digit_sel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            d7seg_q      <= d7seg_d;
            dp_q         <= dp_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign d7seg      = d7seg_q;
    assign dp         = dp_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_scan_display.sv
// ============================================================================
// Module      : tb_hex_scan_display
// Description : Self-checking bench for hex_scan_display (4 digits, dwell 4).
//               Blanking scenarios compiled in with HEX_SCAN_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_scan_display;

    localparam int N = 4;
    localparam int S = 4;
    localparam int F = N * S;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
`ifdef HEX_SCAN_LZB_EN
    logic        blank_lz = 1'b0;
`endif
    logic [6:0]  d7seg;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_done;

    always #5 clk = ~clk;

    hex_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
`ifdef HEX_SCAN_LZB_EN
        .blank_lz   (blank_lz),
`endif
        .d7seg      (d7seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed cycles since reset and the two buffers
    int          t = 0;
    logic [15:0] pend_val = '0, disp_val = '0;
    logic [3:0]  pend_dp = '0, disp_dp = '0;
    bit          pend_v = 0;
    logic [3:0]  exp_sel = '0;
    logic [6:0]  exp_seg = '0;
    logic        exp_dp = 1'b0, exp_fd = 1'b0;

    function automatic logic [6:0] seg_ref(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    // One clock: model what the outputs must show after this edge, then
    // apply the edge's buffer updates (commit before capture).
    task automatic tick();
        int          d;
        logic [15:0] shown;
        bit          lz;
        @(posedge clk);
        if (!rst_n) begin
            t = 0; exp_sel = '0; exp_seg = '0; exp_dp = 1'b0; exp_fd = 1'b0;
            pend_v = 0; pend_val = '0; pend_dp = '0; disp_val = '0; disp_dp = '0;
        end else begin
            t++;
            d     = ((t - 1) / S) % N;
            shown = disp_val >> (4 * d);
`ifdef HEX_SCAN_LZB_EN
            lz = blank_lz;
`else
            lz = 0;
`endif
            exp_sel = 4'(1 << d);
            exp_seg = (lz && d > 0 && shown == 16'h0) ? 7'b0 : seg_ref(shown[3:0]);
            exp_dp  = disp_dp[d];
            exp_fd  = (t % F == 0);
            if (exp_fd && pend_v) begin
                disp_val = pend_val; disp_dp = pend_dp; pend_v = 0;
            end
            if (load) begin
                pend_val = value; pend_dp = dp_in; pend_v = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({digit_sel, d7seg, dp, frame_done} !== 13'b0) begin
                errors++;
                $display("FAIL reset: got sel=%b seg=%b dp=%b fd=%b, expected all zero",
                         digit_sel, d7seg, dp, frame_done);
            end
        end
    endtask

    task automatic test_scan();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            checks++;
            if ({digit_sel, d7seg, dp, frame_done} !== {exp_sel, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL scan t=%0d: got sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                         t, digit_sel, d7seg, dp, frame_done, exp_sel, exp_seg, exp_dp, exp_fd);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        for (int i = 0; i < 3 * F + 6; i++) begin
            if (i == 6) begin value = 16'h12AF; dp_in = 4'b0100; load = 1'b1; end
            else load = 1'b0;
            tick();
            checks++;
            if ({digit_sel, d7seg, dp, frame_done} !== {exp_sel, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL load_mid t=%0d: got sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                         t, digit_sel, d7seg, dp, frame_done, exp_sel, exp_seg, exp_dp, exp_fd);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_two_loads();
        for (int i = 0; i < 3 * F; i++) begin
            load = 1'b0;
            if (i == 2) begin value = 16'h1111; dp_in = 4'b0001; load = 1'b1; end
            if (i == 7) begin value = 16'h2222; dp_in = 4'b1000; load = 1'b1; end
            tick();
            checks++;
            if ({digit_sel, d7seg, dp, frame_done} !== {exp_sel, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL two_loads t=%0d: got sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                         t, digit_sel, d7seg, dp, frame_done, exp_sel, exp_seg, exp_dp, exp_fd);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_load_on_boundary();
        value = 16'hC3D5; dp_in = 4'b0011; load = 1'b1;
        for (int i = 0; i < 4 * F; i++) begin
            // second load lands exactly on the edge that ends the frame
            if ((t + 1) % F == 0 && i > 2 && i < F + 2) begin
                value = 16'h9E8B; dp_in = 4'b1100; load = 1'b1;
            end
            tick();
            load = 1'b0;
            checks++;
            if ({digit_sel, d7seg, dp, frame_done} !== {exp_sel, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL boundary_load t=%0d: got sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                         t, digit_sel, d7seg, dp, frame_done, exp_sel, exp_seg, exp_dp, exp_fd);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 2 * F + 8; i++) begin
            load  = (i == 5);
            rst_n = (i != 6);
            if (i == 5) begin value = 16'h7B46; dp_in = 4'b1111; end
            tick();
            checks++;
            if ({digit_sel, d7seg, dp, frame_done} !== {exp_sel, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL reset_mid t=%0d: got sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                         t, digit_sel, d7seg, dp, frame_done, exp_sel, exp_seg, exp_dp, exp_fd);
            end
        end
        load = 1'b0; rst_n = 1'b1;
    endtask

`ifdef HEX_SCAN_LZB_EN
    task automatic test_lzb();
        blank_lz = 1'b1;
        for (int i = 0; i < 6 * F; i++) begin
            load = 1'b0;
            if (i == 1)     begin value = 16'h0050; dp_in = 4'b0100; load = 1'b1; end
            if (i == 3 * F) begin value = 16'h0000; dp_in = 4'b0000; load = 1'b1; end
            tick();
            checks++;
            if ({digit_sel, d7seg, dp, frame_done} !== {exp_sel, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL lzb t=%0d: got sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                         t, digit_sel, d7seg, dp, frame_done, exp_sel, exp_seg, exp_dp, exp_fd);
            end
        end
        load = 1'b0; blank_lz = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 12 * F; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 1) == 0) value = value & 16'h00FF;
            dp_in = 4'($urandom);
`ifdef HEX_SCAN_LZB_EN
            blank_lz = 1'($urandom);
`endif
            tick();
            checks++;
            if ({digit_sel, d7seg, dp, frame_done} !== {exp_sel, exp_seg, exp_dp, exp_fd}) begin
                errors++;
                $display("FAIL random t=%0d: got sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                         t, digit_sel, d7seg, dp, frame_done, exp_sel, exp_seg, exp_dp, exp_fd);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_mid_frame();
        test_two_loads();
        test_load_on_boundary();
        test_reset_mid_frame();
`ifdef HEX_SCAN_LZB_EN
        test_lzb();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hex_scan_display.md
# hex_scan_display

Parametrised, time-multiplexed driver for a bank of common-anode/common-cathode 7-segment digits showing a hexadecimal value. It takes a packed word of NUM_DIGITS nibbles, double-buffers it so the display never tears mid-frame, and scans one digit at a time with a programmable dwell. It sits between the datapath register that produces the value and the board's segment/digit-enable pins, and replaces the single-digit combinational hex decoder.

## Interface
- NUM_DIGITS, 4: digits in the bank; 1..8.
- SCAN_DIV, 50000: clock cycles each digit is enabled; ≥2.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- value  in  4*NUM_DIGITS  packed hex value; nibble i → digit i, digit 0 least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- load  in  1  one-cycle strobe; captures value and dp_in.
- blank_lz  in  1  leading-zero blanking enable (present only with HEX_SCAN_LZB_EN).
- d7seg  out  7  segments, bit0=a … bit6=g, 1 = lit (0 → 7'b0111111, F → 7'b1110001, d lower-case, b lower-case).
- dp  out  1  decimal point for the active digit, 1 = lit.
- digit_sel  out  NUM_DIGITS  one-hot digit enable, 1 = enabled.
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

## Operation
- Pending buffer: on load=1, value/dp_in captured into pending regs next edge; pending_valid set. Later load before frame end overwrites (last load wins).
- Display buffer: copied from pending at frame boundary (same edge frame_done asserts) only if pending_valid; pending_valid then cleared. load coinciding with the boundary edge: the old pending contents are committed, the new capture stays pending for the next frame.
- Prescaler: counts 0..SCAN_DIV-1, wraps to 0. At terminal count digit index advances; index NUM_DIGITS-1 wraps to 0 and frame_done pulses.
- Output stage (registered): digit_sel = one-hot(index); d7seg = decode(display nibble[index]); dp = display dp[index].
- Leading-zero blanking (macro on, blank_lz=1): digit i>0 shows d7seg=0 if nibble i and all higher nibbles are zero; digit 0 never blanked; dp unaffected. blank_lz sampled live each cycle.
- Reset: prescaler 0, index 0, pending/display regs 0, pending_valid 0; d7seg=0, dp=0, digit_sel=0, frame_done=0. Reset mid-frame drops any pending load.

## Timing
- Outputs lag index by exactly 1 cycle; first cycle after rst_n rises, digit_sel=0001, d7seg=0111111.
- Each digit enabled for exactly SCAN_DIV cycles; frame = NUM_DIGITS*SCAN_DIV cycles.
- load → visible: pending one edge after load; displayed from the first digit-0 slot following the next frame boundary (max NUM_DIGITS*SCAN_DIV+2 cycles).
- frame_done high exactly one cycle per frame, on the edge digit_sel changes to digit 0 minus one (i.e. concurrent with index wrap, one cycle before digit_sel shows digit 0).
- digit_sel always exactly one-hot outside reset; never two digits on.

## Configuration
- HEX_SCAN_LZB_EN defined: blank_lz port and blanking logic present as above.
- Undefined: no blank_lz port; every digit always decoded, zeros shown as 0.

## Structure
- Shared package: segment-code constants for 0–F, SEG_BLANK=7'b0, bit-order definition.
- One sub-module natural: hex_seg_decode (4-bit nibble → 7-bit code, combinational, package constants).

## Test plan
- NUM_DIGITS=4, SCAN_DIV=4: reset, release → digit_sel cycles 0001,0010,0100,1000 every 4 cycles; d7seg=0111111 in all slots; frame_done every 16 cycles.
- load value=16'h12AF, dp_in=4'b0100 mid-frame → old contents until boundary; next frame digit0=1110001, digit1=1110111, digit2=1011011 with dp=1, digit3=0000110.
- Two loads in one frame (16'h1111 then 16'h2222) → only 2222 ever displayed.
- Macro on, blank_lz=1, value=16'h0050 → digits 3,2 d7seg=0, digit1=1101101, digit0=0111111; value=0 → only digit0 lit.
- rst_n low for 1 cycle mid-slot with pending load → all outputs 0 next cycle, restart at digit 0 showing 0, pending discarded.
- load on frame_done edge → previous pending committed, new value appears one frame later.
